// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake fabric: default payload width and the
// pointer/count width helper.
package handshake_pkg;

    localparam int DEFAULT_DATA_WIDTH = 37;

    // Smallest w >= 1 with 2**w >= n.
    function automatic int width_of(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/handshake_fifo_155_ptr.sv
// Modulo-DEPTH wrapping pointer with increment enable. The wrap is explicit,
// so DEPTH need not be a power of two.
module handshake_fifo_155_ptr
    import handshake_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = width_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST_C = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_nxt_s;

    // Next pointer value: hold, step, or wrap to zero after the last slot.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (inc) begin
            if (ptr_r == LAST_C) begin
                ptr_nxt_s = {PTR_W{1'b0}};
            end else begin
                ptr_nxt_s = ptr_r + PTR_W'(1'b1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= {PTR_W{1'b0}};
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/handshake_fifo_155.sv
// Elastic valid/ready FIFO stage holding up to DEPTH tokens in order.
// Define HANDSHAKE_FIFO_BYPASS_EN for transparent (zero-latency when empty) mode.
module handshake_fifo_155
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            ins,
    input  logic                             ins_valid,
    output logic                             ins_ready,
    output logic [DATA_WIDTH-1:0]            outs,
    output logic                             outs_valid,
    input  logic                             outs_ready,
    output logic [width_of(DEPTH + 1)-1:0]   count
);

    localparam int PTR_W = width_of(DEPTH);
    localparam int CNT_W = width_of(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0]      cnt_r;
    logic [PTR_W-1:0]      wr_ptr_s;
    logic [PTR_W-1:0]      rd_ptr_s;

    logic                  empty_s;
    logic                  full_s;
    logic                  ins_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic                  outs_valid_s;
    logic [DATA_WIDTH-1:0] outs_s;

    handshake_fifo_155_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_en_s),
        .ptr (wr_ptr_s)
    );

    handshake_fifo_155_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_en_s),
        .ptr (rd_ptr_s)
    );

    // Flags, handshakes and storage enables; ready never looks at outs_ready.
    always_comb begin
        empty_s      = (cnt_r == {CNT_W{1'b0}});
        full_s       = (cnt_r == FULL_C);
        ins_ready_s  = ~full_s & rst;
        push_s       = ins_valid & ins_ready_s;
        outs_valid_s = 1'b0;
        outs_s       = mem_r[rd_ptr_s];
        pop_s        = 1'b0;
        wr_en_s      = 1'b0;
        rd_en_s      = 1'b0;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
        // An empty FIFO forwards the input; a token consumed that way is never written.
        outs_valid_s = ~empty_s | (ins_valid & rst);
        if (empty_s && rst) begin
            outs_s = ins;
        end else begin
            outs_s = mem_r[rd_ptr_s];
        end
        pop_s   = outs_valid_s & outs_ready;
        wr_en_s = push_s & ~(empty_s & outs_ready);
        rd_en_s = pop_s & ~empty_s;
`else
        outs_valid_s = ~empty_s;
        outs_s       = mem_r[rd_ptr_s];
        pop_s        = outs_valid_s & outs_ready;
        wr_en_s      = push_s;
        rd_en_s      = pop_s;
`endif
    end

    // Storage array; every entry clears on reset so no stale payload survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_s] <= ins;
        end else begin
            mem_r[wr_ptr_s] <= mem_r[wr_ptr_s];
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            case ({wr_en_s, rd_en_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1'b1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign ins_ready  = ins_ready_s;
    assign outs_valid = outs_valid_s;
    assign outs       = outs_s;
    assign count      = cnt_r;

endmodule
